program_store: RTL and testbench

Instruction memory and front-panel program loader that sits directly upstream of the microprocessor core. It drives the core's `instruction` input from its `instruction_address` (PC) output. In LOAD mode, the user keys 8-bit instructions on switches and commits each one with a debounced push button into consecutive locations. In RUN mode, it serves those instructions and releases the core to execute.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/button_debouncer.sv | 49 ++++
 rtl/program_store.sv | 112 +++++++++++
 tb/tb_program_store.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the microprocessor and its program store:
// opcodes, the NOP instruction word and the loader state encoding.
package cpu_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

    // Jump with offset 0 simply advances the PC by one.
    localparam logic [7:0] NOP_INSTR = {OP_JUMP, 6'b00_0000};

    typedef enum logic {
        STATE_LOAD = 1'b0,
        STATE_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a bouncing push button, debounces it, and emits a
// one-cycle pulse on each rising edge of the debounced level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level_prev;
    logic [CNT_W-1:0] count;

    // The counter only runs while the synchronised input disagrees with
    // the accepted level; any agreement restarts the qualification window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            count      <= '0;
        end else begin
            sync_1     <= raw;
            sync_2     <= sync_1;
            level_prev <= level;
            if (sync_2 != level) begin
                if (count == CNT_LAST) begin
                    level <= sync_2;
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

    assign press = level & ~level_prev;

endmodule

// File: rtl/program_store.sv
// Instruction memory with a front-panel loader: words are keyed in LOAD
// mode with a debounced button and served to the core in RUN mode.
module program_store
    import cpu_pkg::*;
#(
    parameter int DEPTH           = 32,
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int ADDR_W         = $clog2(DEPTH)
) (
    input  logic              oscillator,
    input  logic              reset,
    input  logic              load_mode,
    input  logic              load_button,
    input  logic [7:0]        load_data,
    input  logic [7:0]        instruction_address,
    output logic [7:0]        instruction,
    output logic              run_enable,
    output logic [ADDR_W-1:0] load_pointer,
    output logic              load_full,
    output logic              write_ack
);

    state_t     state;
    state_t     next_state;
    logic       mode_sync_1;
    logic       mode_sync;
    logic       press;
    logic       button_level;
    logic       do_write;
    logic       enter_load;
    logic [7:0] mem [DEPTH];

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (oscillator),
        .reset (reset),
        .raw   (load_button),
        .level (button_level),
        .press (press)
    );

    always_ff @(posedge oscillator) begin
        if (reset) begin
            mode_sync_1 <= 1'b0;
            mode_sync   <= 1'b0;
            state       <= STATE_RUN;
        end else begin
            mode_sync_1 <= load_mode;
            mode_sync   <= mode_sync_1;
            state       <= next_state;
        end
    end

    // A press is only honoured while staying in LOAD, so presses that
    // coincide with either mode change are dropped.
    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        enter_load = 1'b0;
        case (state)
            STATE_LOAD: begin
                if (!mode_sync) begin
                    next_state = STATE_RUN;
                end else if (press && !load_full) begin
                    do_write = 1'b1;
                end
            end
            STATE_RUN: begin
                if (mode_sync) begin
                    next_state = STATE_LOAD;
                    enter_load = 1'b1;
                end
            end
            default: next_state = STATE_RUN;
        endcase
    end

    always_ff @(posedge oscillator) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_INSTR;
            end
            load_pointer <= '0;
            load_full    <= 1'b0;
            write_ack    <= 1'b0;
            instruction  <= NOP_INSTR;
        end else begin
            write_ack <= do_write;
            if (enter_load) begin
                load_pointer <= '0;
                load_full    <= 1'b0;
            end else if (do_write) begin
                mem[load_pointer] <= load_data;
                if (load_pointer == ADDR_W'(DEPTH - 1)) begin
                    load_pointer <= '0;
                    load_full    <= 1'b1;
                end else begin
                    load_pointer <= load_pointer + 1'b1;
                end
            end
            if (state == STATE_RUN && instruction_address < 8'(DEPTH)) begin
                instruction <= mem[instruction_address[ADDR_W-1:0]];
            end else begin
                instruction <= NOP_INSTR;
            end
        end
    end

    assign run_enable = (state == STATE_RUN);

endmodule

// File: tb/tb_program_store.sv
// Directed bench for program_store with a short debounce window.
module tb_program_store;

    logic       oscillator;
    logic       reset;
    logic       load_mode;
    logic       load_button;
    logic [7:0] load_data;
    logic [7:0] instruction_address;
    logic [7:0] instruction;
    logic       run_enable;
    logic [4:0] load_pointer;
    logic       load_full;
    logic       write_ack;

    int check_count;
    int pass_count;

    program_store #(
        .DEPTH(32),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .oscillator          (oscillator),
        .reset               (reset),
        .load_mode           (load_mode),
        .load_button         (load_button),
        .load_data           (load_data),
        .instruction_address (instruction_address),
        .instruction         (instruction),
        .run_enable          (run_enable),
        .load_pointer        (load_pointer),
        .load_full           (load_full),
        .write_ack           (write_ack)
    );

    initial oscillator = 1'b0;
    always #5 oscillator = ~oscillator;

    // Advance n clocks and settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge oscillator);
            #1;
        end
    endtask

    task automatic set_mode(input logic m);
        load_mode = m;
        tick(4);
    endtask

    // Hold the button long enough for one press, counting acks.
    task automatic press_word(input logic [7:0] data, output int acks);
        logic prev;
        acks = 0;
        prev = 1'b0;
        load_data   = data;
        load_button = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (write_ack) acks++;
            if (write_ack && prev) acks += 100;
            prev = write_ack;
        end
        load_button = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (write_ack) acks++;
        end
    endtask

    task automatic read_word(input logic [7:0] addr, input logic [7:0] exp, input string name);
        instruction_address = addr;
        tick(1);
        check_count++;
        if (instruction !== exp)
            $display("[TB] FAIL %s addr=%0d instruction=%h expected=%h", name, addr, instruction, exp);
        else
            pass_count++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_mode = 1'b0;
        load_button = 1'b0;
        load_data = 8'h00;
        instruction_address = 8'd0;
        tick(2);
        for (int a = 0; a < 32; a++) read_word(8'(a), 8'hC0, "reset_instr");
        check_count++;
        if (run_enable !== 1'b1 || load_pointer !== 5'd0 || load_full !== 1'b0 || write_ack !== 1'b0)
            $display("[TB] FAIL reset_flags run=%b ptr=%0d full=%b ack=%b expected 1/0/0/0",
                     run_enable, load_pointer, load_full, write_ack);
        else
            pass_count++;
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_load_and_run();
        int acks;
        logic [7:0] words [3] = '{8'h1B, 8'h6C, 8'hC3};
        set_mode(1'b1);
        check_count++;
        if (run_enable !== 1'b0)
            $display("[TB] FAIL load_run_enable run_enable=%b expected=0", run_enable);
        else
            pass_count++;
        for (int i = 0; i < 3; i++) begin
            press_word(words[i], acks);
            check_count++;
            if (acks !== 1)
                $display("[TB] FAIL load_ack word=%0d acks=%0d expected=1", i, acks);
            else
                pass_count++;
        end
        check_count++;
        if (load_pointer !== 5'd3)
            $display("[TB] FAIL load_pointer pointer=%0d expected=3", load_pointer);
        else
            pass_count++;
        set_mode(1'b0);
        check_count++;
        if (run_enable !== 1'b1)
            $display("[TB] FAIL run_enable run_enable=%b expected=1", run_enable);
        else
            pass_count++;
        for (int i = 0; i < 3; i++) read_word(8'(i), words[i], "run_read");
        read_word(8'd3, 8'hC0, "run_unwritten");
    endtask

    task automatic test_debounce();
        int acks;
        set_mode(1'b1);
        acks = 0;
        load_data = 8'h55;
        for (int len = 1; len <= 3; len++) begin
            load_button = 1'b1;
            for (int i = 0; i < len; i++) begin
                tick(1);
                if (write_ack) acks++;
            end
            load_button = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick(1);
                if (write_ack) acks++;
            end
        end
        check_count++;
        if (acks !== 0 || load_pointer !== 5'd0)
            $display("[TB] FAIL debounce_short acks=%0d ptr=%0d expected 0/0", acks, load_pointer);
        else
            pass_count++;
        load_button = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (write_ack) acks++;
        end
        load_button = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (write_ack) acks++;
        end
        check_count++;
        if (acks !== 1 || load_pointer !== 5'd1)
            $display("[TB] FAIL debounce_long acks=%0d ptr=%0d expected 1/1", acks, load_pointer);
        else
            pass_count++;
    endtask

    task automatic test_full();
        int acks;
        int total;
        set_mode(1'b0);
        set_mode(1'b1);
        check_count++;
        if (load_pointer !== 5'd0 || load_full !== 1'b0)
            $display("[TB] FAIL reenter_load ptr=%0d full=%b expected 0/0", load_pointer, load_full);
        else
            pass_count++;
        total = 0;
        for (int i = 0; i < 32; i++) begin
            check_count++;
            if (load_full !== 1'b0)
                $display("[TB] FAIL full_early index=%0d full=%b expected=0", i, load_full);
            else
                pass_count++;
            press_word(8'(i), acks);
            total += acks;
        end
        check_count++;
        if (total !== 32 || load_full !== 1'b1 || load_pointer !== 5'd0)
            $display("[TB] FAIL full_after_32 acks=%0d full=%b ptr=%0d expected 32/1/0",
                     total, load_full, load_pointer);
        else
            pass_count++;
        press_word(8'hFF, acks);
        check_count++;
        if (acks !== 0)
            $display("[TB] FAIL full_ignore acks=%0d expected=0", acks);
        else
            pass_count++;
        set_mode(1'b0);
        read_word(8'd0, 8'h00, "full_loc0");
        read_word(8'd5, 8'h05, "full_loc5");
        read_word(8'd31, 8'h1F, "full_loc31");
        set_mode(1'b1);
        check_count++;
        if (load_full !== 1'b0 || load_pointer !== 5'd0)
            $display("[TB] FAIL full_clear full=%b ptr=%0d expected 0/0", load_full, load_pointer);
        else
            pass_count++;
    endtask

    task automatic test_range_mode();
        set_mode(1'b0);
        read_word(8'd40, 8'hC0, "range_40");
        read_word(8'd255, 8'hC0, "range_255");
        read_word(8'd32, 8'hC0, "range_32");
        read_word(8'd31, 8'h1F, "range_31");
        set_mode(1'b1);
        read_word(8'd31, 8'hC0, "load_nop_31");
        read_word(8'd1, 8'hC0, "load_nop_1");
        check_count++;
        if (run_enable !== 1'b0)
            $display("[TB] FAIL load_mode_run_enable run_enable=%b expected=0", run_enable);
        else
            pass_count++;
    endtask

    task automatic test_reset_mid();
        int acks;
        int total;
        total = 0;
        for (int i = 0; i < 5; i++) begin
            press_word(8'hA0 + 8'(i), acks);
            total += acks;
        end
        check_count++;
        if (total !== 5 || load_pointer !== 5'd5)
            $display("[TB] FAIL mid_writes acks=%0d ptr=%0d expected 5/5", total, load_pointer);
        else
            pass_count++;
        load_mode = 1'b0;
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (write_ack) acks++;
        end
        check_count++;
        if (run_enable !== 1'b1 || load_pointer !== 5'd0 || load_full !== 1'b0 || acks !== 0)
            $display("[TB] FAIL mid_reset run=%b ptr=%0d full=%b acks=%0d expected 1/0/0/0",
                     run_enable, load_pointer, load_full, acks);
        else
            pass_count++;
        reset = 1'b0;
        tick(4);
        for (int a = 0; a < 6; a++) read_word(8'(a), 8'hC0, "mid_mem");
        read_word(8'd31, 8'hC0, "mid_mem_31");
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        test_reset();
        test_load_and_run();
        test_debounce();
        test_full();
        test_range_mode();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
